ball_engine: RTL and testbench
==============================

BALL_ENGINE -- requirements
Module: ball_engine

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- H_ACTIVE, 640, visible width in pixels.
- V_ACTIVE, 480, visible height in pixels.
- BALL_SIZE, 8, ball side in pixels.
- PAD_W, 8, paddle width.
- PAD_H, 64, paddle height.
- LEFT_PAD_X, 16, left paddle left edge.
- RIGHT_PAD_X, 616, right paddle left edge.
- SPEED, 2, pixels per frame, each axis.
- MISS_FRAMES, 60, frames held after a miss.

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk  in  1  pixel clock, shared with the sync generator.
- rst_n  in  1  synchronous active-low reset.
- vsync  in  1  active-low vertical sync from the sync generator, synchronous to clk.
- pad_l_y  in  10  left paddle top row.
- pad_r_y  in  10  right paddle top row.
- serve  in  1  one-cycle serve pulse from the key level-to-pulse stage.
- ball_x  out  10  ball left column, consumed by the colour stage.
- ball_y  out  10  ball top row.
- fell  out  1  one-cycle miss pulse, consumed by the buzzer.
- hit  out  1  one-cycle paddle-hit pulse.
- miss_side  out  1  0 = left player missed, 1 = right player missed.
- busy  out  1  high in MOVE or MISS.

Function
REQ-003 An internal frame tick SHALL assert for exactly one cycle on each vsync 1->0 edge, detected with one register; all motion SHALL update only on a tick.
REQ-004 FSM states SHALL be IDLE, MOVE and MISS.
REQ-005 IDLE: the ball SHALL hold at centre (x=(H_ACTIVE-BALL_SIZE)/2=316, y=(V_ACTIVE-BALL_SIZE)/2=236).
- A serve pulse SHALL move the FSM to MOVE on the next cycle.
- The first motion SHALL occur on the next tick.
REQ-006 MOVE, per tick: nx = x±SPEED and ny = y±SPEED according to the direction bits dx and dy (1 = +).
REQ-007 Vertical wall rule:
- If dy=1 and ny >= V_ACTIVE-BALL_SIZE: y SHALL become V_ACTIVE-BALL_SIZE and dy SHALL become 0.
- If dy=0 and y < SPEED: y SHALL become 0 and dy SHALL become 1.
REQ-008 Right paddle rule:
- Condition: dx=1, x+BALL_SIZE <= RIGHT_PAD_X, nx+BALL_SIZE >= RIGHT_PAD_X, and vertical overlap (y+BALL_SIZE > pad_r_y and y < pad_r_y+PAD_H).
- Response: x SHALL become RIGHT_PAD_X-BALL_SIZE, dx SHALL become 0, and hit SHALL pulse one cycle.
REQ-009 Left paddle rule: mirror of REQ-008 against edge LEFT_PAD_X+PAD_W, using pad_l_y.
- On a hit, x SHALL become LEFT_PAD_X+PAD_W and dx SHALL become 1.
REQ-010 Miss rule: without a paddle hit, if nx reaches H_ACTIVE-BALL_SIZE (right) or underflows below SPEED (left):
- x SHALL be clamped to that edge.
- fell SHALL pulse one cycle.
- miss_side SHALL be set (1 = right, 0 = left).
- The FSM SHALL enter MISS.
REQ-011 A wall bounce and a paddle hit or miss on the same tick SHALL both apply.
REQ-012 Paddle overlap SHALL use the paddle inputs sampled on the tick cycle.
REQ-013 MISS: the ball SHALL freeze for MISS_FRAMES ticks, then return to IDLE at centre, with dx pointing toward the side that missed and dy=1.
REQ-014 serve SHALL be ignored in MOVE and in MISS.
REQ-015 ball_x, ball_y, fell, hit and miss_side SHALL be registered outputs.
REQ-016 Positions SHALL be computed at 11 bits so no intermediate result wraps; outputs SHALL never exceed H_ACTIVE-BALL_SIZE or V_ACTIVE-BALL_SIZE.

Reset
REQ-017 With rst_n=0 at a clk edge, the following SHALL hold on the next cycle:
- FSM in IDLE; ball_x=316, ball_y=236.
- dx=1, dy=1.
- fell=0, hit=0, miss_side=0, busy=0.
- Frame counter and vsync edge register cleared.
REQ-018 Reset mid-MOVE or mid-MISS SHALL abort with no fell or hit pulse.

Structure
REQ-019 Screen constants, paddle geometry and the FSM state encoding SHALL live in shared package pong_pkg, which the colour stage also uses.
REQ-020 Vsync edge detection SHALL be a sub-module vsync_tick (clk, rst_n, vsync -> tick).

Verification (MISS_FRAMES=3)
REQ-021 Reset then 5 vsync pulses with no serve -> ball stays at (316,236), busy=0, no pulses.
REQ-022 Serve, dx=1, dy=1, pad_r_y=200 -> after 1 tick ball=(318,238); busy=1.
REQ-023 Ball at y=470, dy=1, tick -> y=472 and dy=0.
REQ-024 Ball at x=606, y=220, dx=1, pad_r_y=200 -> x=608, hit pulses once, dx=0.
- Same stimulus with pad_r_y=0 -> no hit; the ball continues and the right miss fires at x=632.
REQ-025 Right miss -> fell high exactly 1 cycle, miss_side=1.
- 3 ticks later: IDLE at centre with dx=1.
- A serve during MISS is ignored.
REQ-026 rst_n=0 mid-MOVE -> next cycle: ball=(316,236), fell=0, hit=0, busy=0.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared Pong definitions: screen geometry, paddle geometry and ball FSM encoding.
// The colour stage imports this package as well, so keep it free of engine-only logic.
package pong_pkg;

    localparam int H_ACTIVE_DEF    = 640;
    localparam int V_ACTIVE_DEF    = 480;
    localparam int BALL_SIZE_DEF   = 8;
    localparam int PAD_W_DEF       = 8;
    localparam int PAD_H_DEF       = 64;
    localparam int LEFT_PAD_X_DEF  = 16;
    localparam int RIGHT_PAD_X_DEF = 616;
    localparam int SPEED_DEF       = 2;
    localparam int MISS_FRAMES_DEF = 60;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MOVE = 2'd1;
    localparam logic [1:0] ST_MISS = 2'd2;

    // True when a ball whose top row is ball_top vertically overlaps a paddle.
    function automatic logic overlaps(input logic [10:0] ball_top,
                                      input logic [10:0] pad_top,
                                      input logic [10:0] ball_size,
                                      input logic [10:0] pad_h);
        return ((ball_top + ball_size) > pad_top) && (ball_top < (pad_top + pad_h));
    endfunction

endpackage

// File: rtl/vsync_tick.sv
// Frame tick generator: one-cycle pulse on every falling edge of the active-low vsync.
module vsync_tick (
    input  logic clk,
    input  logic rst_n,
    input  logic vsync,
    output logic tick
);

    logic vsync_q;

    // Remember last cycle's vsync level; cleared on reset so no tick fires right after it.
    always_ff @(posedge clk) begin
        if (!rst_n) vsync_q <= 1'b0;
        else        vsync_q <= vsync;
    end

    assign tick = vsync_q & ~vsync;

endmodule

// File: rtl/ball_engine.sv
// Pong ball engine: serves, moves and bounces the ball once per frame and reports
// paddle hits and misses. All motion happens only on the frame tick.
module ball_engine
    import pong_pkg::*;
#(
    parameter int H_ACTIVE    = H_ACTIVE_DEF,
    parameter int V_ACTIVE    = V_ACTIVE_DEF,
    parameter int BALL_SIZE   = BALL_SIZE_DEF,
    parameter int PAD_W       = PAD_W_DEF,
    parameter int PAD_H       = PAD_H_DEF,
    parameter int LEFT_PAD_X  = LEFT_PAD_X_DEF,
    parameter int RIGHT_PAD_X = RIGHT_PAD_X_DEF,
    parameter int SPEED       = SPEED_DEF,
    parameter int MISS_FRAMES = MISS_FRAMES_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vsync,
    input  logic [9:0] pad_l_y,
    input  logic [9:0] pad_r_y,
    input  logic       serve,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic       fell,
    output logic       hit,
    output logic       miss_side,
    output logic       busy
);

    // All geometry is widened to 11 bits so sums and differences never wrap.
    localparam logic [10:0] SPD    = 11'(SPEED);
    localparam logic [10:0] BS     = 11'(BALL_SIZE);
    localparam logic [10:0] PH     = 11'(PAD_H);
    localparam logic [10:0] X_MAX  = 11'(H_ACTIVE - BALL_SIZE);
    localparam logic [10:0] Y_MAX  = 11'(V_ACTIVE - BALL_SIZE);
    localparam logic [10:0] R_EDGE = 11'(RIGHT_PAD_X);
    localparam logic [10:0] L_EDGE = 11'(LEFT_PAD_X + PAD_W);
    localparam logic [9:0]  X_CTR  = 10'((H_ACTIVE - BALL_SIZE) / 2);
    localparam logic [9:0]  Y_CTR  = 10'((V_ACTIVE - BALL_SIZE) / 2);
    localparam logic [9:0]  X_TOP  = 10'(H_ACTIVE - BALL_SIZE);
    localparam logic [9:0]  Y_TOP  = 10'(V_ACTIVE - BALL_SIZE);
    localparam logic [9:0]  X_RHIT = 10'(RIGHT_PAD_X - BALL_SIZE);
    localparam logic [9:0]  X_LHIT = 10'(LEFT_PAD_X + PAD_W);

    localparam int CNT_W = (MISS_FRAMES > 1) ? $clog2(MISS_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MISS_FRAMES - 1);

    logic             tick;
    logic [1:0]       state;
    logic             dx;
    logic             dy;
    logic [CNT_W-1:0] frame_cnt;

    logic [10:0] cx, cy, nx, ny;
    logic [9:0]  y_next;
    logic        dy_next;
    logic        hit_r, hit_l, miss_r, miss_l;

    vsync_tick u_vsync_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .vsync (vsync),
        .tick  (tick)
    );

    assign busy = (state != ST_IDLE);

    // Candidate next position plus wall, paddle and miss decisions for this tick.
    always_comb begin
        cx = {1'b0, ball_x};
        cy = {1'b0, ball_y};
        nx = dx ? (cx + SPD) : (cx - SPD);
        ny = dy ? (cy + SPD) : (cy - SPD);

        y_next  = ny[9:0];
        dy_next = dy;
        if (dy) begin
            if (ny >= Y_MAX) begin
                y_next  = Y_TOP;
                dy_next = 1'b0;
            end
        end else if (cy < SPD) begin
            y_next  = 10'd0;
            dy_next = 1'b1;
        end

        hit_r  = dx && ((cx + BS) <= R_EDGE) && ((nx + BS) >= R_EDGE)
                    && overlaps(cy, {1'b0, pad_r_y}, BS, PH);
        hit_l  = !dx && (cx >= L_EDGE) && (nx <= L_EDGE)
                    && overlaps(cy, {1'b0, pad_l_y}, BS, PH);
        // A left-moving ball closer to the edge than one step would underflow: that is the miss.
        miss_r = dx && !hit_r && (nx >= X_MAX);
        miss_l = !dx && !hit_l && (cx < SPD);
    end

    // Ball FSM: idle at centre, move per tick, freeze after a miss, then re-centre.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ball_x    <= X_CTR;
            ball_y    <= Y_CTR;
            dx        <= 1'b1;
            dy        <= 1'b1;
            fell      <= 1'b0;
            hit       <= 1'b0;
            miss_side <= 1'b0;
            frame_cnt <= '0;
        end else begin
            fell <= 1'b0;
            hit  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    ball_x <= X_CTR;
                    ball_y <= Y_CTR;
                    if (serve) state <= ST_MOVE;
                end
                ST_MOVE: begin
                    if (tick) begin
                        ball_y <= y_next;
                        dy     <= dy_next;
                        if (hit_r) begin
                            ball_x <= X_RHIT;
                            dx     <= 1'b0;
                            hit    <= 1'b1;
                        end else if (hit_l) begin
                            ball_x <= X_LHIT;
                            dx     <= 1'b1;
                            hit    <= 1'b1;
                        end else if (miss_r) begin
                            ball_x    <= X_TOP;
                            fell      <= 1'b1;
                            miss_side <= 1'b1;
                            frame_cnt <= '0;
                            state     <= ST_MISS;
                        end else if (miss_l) begin
                            ball_x    <= 10'd0;
                            fell      <= 1'b1;
                            miss_side <= 1'b0;
                            frame_cnt <= '0;
                            state     <= ST_MISS;
                        end else begin
                            ball_x <= nx[9:0];
                        end
                    end
                end
                ST_MISS: begin
                    if (tick) begin
                        if (frame_cnt == CNT_LAST) begin
                            state     <= ST_IDLE;
                            ball_x    <= X_CTR;
                            ball_y    <= Y_CTR;
                            dx        <= miss_side;
                            dy        <= 1'b1;
                            frame_cnt <= '0;
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ball_engine.sv
// Self-checking bench for ball_engine: directed scenarios plus randomized play,
// compared every cycle against a frame-level behavioural model of the ball.
module tb_ball_engine;

    localparam int MISS_FRAMES = 3;

    logic       clk;
    logic       rst_n;
    logic       vsync;
    logic [9:0] pad_l_y;
    logic [9:0] pad_r_y;
    logic       serve;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic       fell;
    logic       hit;
    logic       miss_side;
    logic       busy;

    int checks = 0;
    int errors = 0;

    // Reference model: plain signed integers and a play phase (0 idle, 1 playing, 2 frozen).
    int phase, mx, my, mdx, mdy, mside, frames_left;
    int prev_vs;
    int ehit, efell;

    ball_engine #(.MISS_FRAMES(MISS_FRAMES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .vsync     (vsync),
        .pad_l_y   (pad_l_y),
        .pad_r_y   (pad_r_y),
        .serve     (serve),
        .ball_x    (ball_x),
        .ball_y    (ball_y),
        .fell      (fell),
        .hit       (hit),
        .miss_side (miss_side),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock of the game rules, applied to the inputs present at this edge.
    task automatic modelStep();
        int t, nx, ny, pl, pr, rh, lh;
        t  = (prev_vs == 1 && vsync == 1'b0) ? 1 : 0;
        pl = int'(pad_l_y);
        pr = int'(pad_r_y);
        ehit  = 0;
        efell = 0;
        if (!rst_n) begin
            prev_vs = 0; phase = 0; mx = 316; my = 236;
            mdx = 1; mdy = 1; mside = 0; frames_left = 0;
            return;
        end
        prev_vs = int'(vsync);
        if (phase == 0) begin
            mx = 316; my = 236;
            if (serve) phase = 1;
        end else if (phase == 1 && t == 1) begin
            nx = mx + (mdx == 1 ? 2 : -2);
            rh = (mdx == 1 && mx + 8 <= 616 && nx + 8 >= 616 && my + 8 > pr && my < pr + 64) ? 1 : 0;
            lh = (mdx == 0 && mx >= 24 && nx <= 24 && my + 8 > pl && my < pl + 64) ? 1 : 0;
            ny = my + (mdy == 1 ? 2 : -2);
            if (mdy == 1 && ny >= 472) begin my = 472; mdy = 0; end
            else if (mdy == 0 && ny < 0) begin my = 0; mdy = 1; end
            else my = ny;
            if (rh == 1) begin mx = 608; mdx = 0; ehit = 1; end
            else if (lh == 1) begin mx = 24; mdx = 1; ehit = 1; end
            else if (nx >= 632) begin mx = 632; efell = 1; mside = 1; phase = 2; frames_left = MISS_FRAMES; end
            else if (nx < 0) begin mx = 0; efell = 1; mside = 0; phase = 2; frames_left = MISS_FRAMES; end
            else mx = nx;
        end else if (phase == 2 && t == 1) begin
            frames_left--;
            if (frames_left == 0) begin
                phase = 0; mx = 316; my = 236; mdx = mside; mdy = 1;
            end
        end
    endtask

    task automatic compareAll();
        checkOutput("ball_x", int'(ball_x), mx);
        checkOutput("ball_y", int'(ball_y), my);
        checkOutput("hit", int'(hit), ehit);
        checkOutput("fell", int'(fell), efell);
        checkOutput("miss_side", int'(miss_side), mside);
        checkOutput("busy", int'(busy), (phase != 0) ? 1 : 0);
    endtask

    // Drive one cycle of inputs, advance the model on the edge, then compare.
    task automatic applyStimulus(input logic r, input logic v, input logic s,
                                 input logic [9:0] pl, input logic [9:0] pr);
        @(negedge clk);
        rst_n = r; vsync = v; serve = s; pad_l_y = pl; pad_r_y = pr;
        @(posedge clk);
        modelStep();
        #1;
        compareAll();
    endtask

    function automatic logic [9:0] track(input int y);
        return (y >= 20) ? 10'(y - 20) : 10'd0;
    endfunction

    function automatic logic [9:0] avoid(input int y);
        return (y < 240) ? 10'd400 : 10'd0;
    endfunction

    // One 8-cycle frame: vsync low for the first two cycles, tick on the first.
    task automatic runFrame(input int serve_cycle, input logic [9:0] pl, input logic [9:0] pr);
        for (int c = 0; c < 8; c++)
            applyStimulus(1'b1, (c >= 2), (c == serve_cycle), pl, pr);
    endtask

    initial begin
        int seen_hit, seen_fell, len, low;
        logic [9:0] rpl, rpr;
        logic s, r;

        rst_n = 1'b0; vsync = 1'b1; serve = 1'b0; pad_l_y = 10'd0; pad_r_y = 10'd200;
        phase = 0; mx = 316; my = 236; mdx = 1; mdy = 1; mside = 0;
        frames_left = 0; prev_vs = 0; ehit = 0; efell = 0;

        // Reset state
        applyStimulus(1'b0, 1'b1, 1'b0, 10'd0, 10'd200);
        applyStimulus(1'b0, 1'b1, 1'b0, 10'd0, 10'd200);
        checkOutput("reset_x", int'(ball_x), 316);
        checkOutput("reset_y", int'(ball_y), 236);
        checkOutput("reset_busy", int'(busy), 0);

        // Vsync pulses without a serve leave the ball parked
        for (int f = 0; f < 5; f++) runFrame(-1, 10'd0, 10'd200);
        checkOutput("idle_x", int'(ball_x), 316);
        checkOutput("idle_y", int'(ball_y), 236);
        checkOutput("idle_busy", int'(busy), 0);

        // Serve, then the first tick moves diagonally down-right
        applyStimulus(1'b1, 1'b1, 1'b1, 10'd0, 10'd200);
        applyStimulus(1'b1, 1'b0, 1'b0, 10'd0, 10'd200);
        checkOutput("serve_x", int'(ball_x), 318);
        checkOutput("serve_y", int'(ball_y), 238);
        checkOutput("serve_busy", int'(busy), 1);
        for (int c = 1; c < 8; c++) applyStimulus(1'b1, (c >= 2), 1'b0, 10'd0, 10'd200);

        // Rally: right paddle tracks the ball until it returns it
        seen_hit = 0;
        for (int f = 0; f < 400 && seen_hit == 0; f++) begin
            for (int c = 0; c < 8; c++) begin
                applyStimulus(1'b1, (c >= 2), 1'b0, track(my), track(my));
                if (ehit == 1 && seen_hit == 0) begin
                    seen_hit = 1;
                    checkOutput("rhit_x", int'(ball_x), 608);
                end
            end
        end
        checkOutput("rhit_seen", seen_hit, 1);

        // Left paddle keeps returning, right paddle stays away: right miss
        seen_fell = 0;
        for (int f = 0; f < 800 && seen_fell == 0; f++) begin
            for (int c = 0; c < 8; c++) begin
                applyStimulus(1'b1, (c >= 2), 1'b0, track(my), avoid(my));
                if (efell == 1 && seen_fell == 0) begin
                    seen_fell = 1;
                    checkOutput("rmiss_x", int'(ball_x), 632);
                    checkOutput("rmiss_side", int'(miss_side), 1);
                end
            end
        end
        checkOutput("rmiss_seen", seen_fell, 1);

        // Frozen for three ticks, serves ignored, then back to centre
        runFrame(3, 10'd0, 10'd0);
        runFrame(3, 10'd0, 10'd0);
        runFrame(-1, 10'd0, 10'd0);
        checkOutput("recentre_x", int'(ball_x), 316);
        checkOutput("recentre_busy", int'(busy), 0);
        applyStimulus(1'b1, 1'b1, 1'b1, 10'd0, 10'd200);
        applyStimulus(1'b1, 1'b0, 1'b0, 10'd0, 10'd200);
        checkOutput("reserve_dx_x", int'(ball_x), 318);

        // Reset in the middle of play
        for (int f = 0; f < 10; f++) runFrame(-1, 10'd0, 10'd200);
        applyStimulus(1'b0, 1'b1, 1'b0, 10'd0, 10'd200);
        checkOutput("midrst_x", int'(ball_x), 316);
        checkOutput("midrst_y", int'(ball_y), 236);
        checkOutput("midrst_busy", int'(busy), 0);
        checkOutput("midrst_hit", int'(hit), 0);

        // Randomized play with ragged frames, occasional serves and resets
        for (int f = 0; f < 2200; f++) begin
            len = $urandom_range(6, 10);
            low = $urandom_range(1, 2);
            rpl = ($urandom_range(0, 9) < 8) ? track(my) : 10'($urandom_range(0, 479));
            rpr = ($urandom_range(0, 9) < 8) ? track(my) : 10'($urandom_range(0, 479));
            for (int c = 0; c < len; c++) begin
                s = ($urandom_range(0, 29) == 0);
                r = ($urandom_range(0, 2999) != 0);
                applyStimulus(r, (c >= low), s, rpl, rpr);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
